lsu_mem_arbiter: RTL and testbench

Shares one external data-memory channel between the NUM_CONSUMERS load/store units of a compute core. Each LSU raises a read or write request. The arbiter grants one request at a time in round-robin order, forwards it to memory, and returns a one-cycle ready pulse (plus read data) to the winning LSU. It sits between the per-thread LSUs and the core's data-memory port.

---
 rtl/lsu_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel
// between the load/store units of a compute core.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IW = $clog2(NUM_CONSUMERS);

  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RESPOND
  } state_t;

  state_t state;
  state_t state_nxt;

  // last_grant doubles as the index of the transaction in flight
  idx_t last_grant;
  logic is_write;

  logic [NUM_CONSUMERS-1:0] req;
  logic                     found;
  idx_t                     pick;
  logic [IW:0]              probe;
  logic                     pick_rd;
  logic [ADDR_BITS-1:0]     pick_raddr;
  logic [ADDR_BITS-1:0]     pick_waddr;
  logic [DATA_BITS-1:0]     pick_wdata;

  assign req = consumer_read_valid | consumer_write_valid;

  // Search last_grant+1, last_grant+2, ... wrapping at NUM_CONSUMERS
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    probe = '0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      probe = {1'b0, last_grant} + (IW+1)'(k);
      if (probe >= (IW+1)'(NUM_CONSUMERS))
        probe = probe - (IW+1)'(NUM_CONSUMERS);
      if (!found && req[probe[IW-1:0]]) begin
        found = 1'b1;
        pick  = probe[IW-1:0];
      end
    end
  end

  always_comb begin
    pick_raddr = '0;
    pick_waddr = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (pick == idx_t'(i)) begin
        pick_raddr = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        pick_waddr = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        pick_wdata = consumer_write_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Reads win over a simultaneous write from the same LSU
  assign pick_rd = consumer_read_valid[pick];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    mem_read_valid       = 1'b0;
    mem_write_valid      = 1'b0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    case (state)
      IDLE: begin
        if (found)
          state_nxt = pick_rd ? READ_WAIT : WRITE_WAIT;
      end
      READ_WAIT: begin
        mem_read_valid = 1'b1;
        if (mem_read_ready) state_nxt = RESPOND;
      end
      WRITE_WAIT: begin
        mem_write_valid = 1'b1;
        if (mem_write_ready) state_nxt = RESPOND;
      end
      RESPOND: begin
        state_nxt = IDLE;
        if (is_write) consumer_write_ready[last_grant] = 1'b1;
        else          consumer_read_ready[last_grant]  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant         <= idx_t'(NUM_CONSUMERS-1);
      is_write           <= 1'b0;
      mem_read_address   <= '0;
      mem_write_address  <= '0;
      mem_write_data     <= '0;
      consumer_read_data <= '0;
    end else begin
      if (state == IDLE && found) begin
        last_grant <= pick;
        is_write   <= !pick_rd;
        if (pick_rd) begin
          mem_read_address <= pick_raddr;
        end else begin
          mem_write_address <= pick_waddr;
          mem_write_data    <= pick_wdata;
        end
      end
      if (state == READ_WAIT && mem_read_ready) begin
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
          if (last_grant == idx_t'(i))
            consumer_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: arbitration order,
// latency, reset abort and ignored memory handshakes.
module tb_lsu_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  consumer_read_valid;
  logic [31:0] consumer_read_address;
  logic [3:0]  consumer_read_ready;
  logic [31:0] consumer_read_data;
  logic [3:0]  consumer_write_valid;
  logic [31:0] consumer_write_address;
  logic [31:0] consumer_write_data;
  logic [3:0]  consumer_write_ready;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [7:0]  mem_read_data;
  logic        mem_write_valid;
  logic [7:0]  mem_write_address;
  logic [7:0]  mem_write_data;
  logic        mem_write_ready;

  int total;
  int bad;

  lsu_mem_arbiter #(
    .NUM_CONSUMERS(4),
    .ADDR_BITS(8),
    .DATA_BITS(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .consumer_read_valid(consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready),
    .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data),
    .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in IDLE with the request already visible
  task automatic xact_read(input int idx, input logic [7:0] addr,
                           input logic [7:0] d, input int lat);
    tick;
    chk("rd_valid", mem_read_valid, 1);
    chk("rd_no_wr", mem_write_valid, 0);
    chk("rd_addr", mem_read_address, addr);
    for (int w = 0; w < lat; w++) begin
      tick;
      chk("rd_wait_rdy", consumer_read_ready, 0);
      chk("rd_wait_vld", mem_read_valid, 1);
    end
    mem_read_ready = 1'b1;
    mem_read_data  = d;
    tick;
    mem_read_ready = 1'b0;
    mem_read_data  = 8'h00;
    chk("rd_ready", consumer_read_ready, 64'd1 << idx);
    chk("rd_wr_rdy0", consumer_write_ready, 0);
    chk("rd_data", consumer_read_data[idx*8 +: 8], d);
    chk("rd_vld_drop", mem_read_valid, 0);
    tick;
    chk("rd_pulse_end", consumer_read_ready, 0);
  endtask

  task automatic xact_write(input int idx, input logic [7:0] addr,
                            input logic [7:0] d);
    tick;
    chk("wr_valid", mem_write_valid, 1);
    chk("wr_no_rd", mem_read_valid, 0);
    chk("wr_addr", mem_write_address, addr);
    chk("wr_data", mem_write_data, d);
    mem_write_ready = 1'b1;
    tick;
    mem_write_ready = 1'b0;
    chk("wr_ready", consumer_write_ready, 64'd1 << idx);
    chk("wr_rd_rdy0", consumer_read_ready, 0);
    chk("wr_vld_drop", mem_write_valid, 0);
    tick;
    chk("wr_pulse_end", consumer_write_ready, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    consumer_read_valid = '0;
    consumer_read_address = '0;
    consumer_write_valid = '0;
    consumer_write_address = '0;
    consumer_write_data = '0;
    mem_read_ready = 1'b0;
    mem_read_data = '0;
    mem_write_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;

    chk("rst_rvalid", mem_read_valid, 0);
    chk("rst_wvalid", mem_write_valid, 0);
    chk("rst_raddr", mem_read_address, 0);
    chk("rst_waddr", mem_write_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_rrdy", consumer_read_ready, 0);
    chk("rst_wrdy", consumer_write_ready, 0);
    chk("rst_rdata", consumer_read_data, 0);

    // single read, memory answers in cycle 2
    consumer_read_address[2*8 +: 8] = 8'h3C;
    consumer_read_valid = 4'b0100;
    xact_read(2, 8'h3C, 8'hA5, 1);
    consumer_read_valid = '0;
    tick;
    chk("rd_hold", consumer_read_data[2*8 +: 8], 8'hA5);

    // simultaneous writes from 0 and 3 after fresh reset
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst2_rdata", consumer_read_data, 0);
    consumer_write_address[0*8 +: 8] = 8'h10;
    consumer_write_data[0*8 +: 8]    = 8'h11;
    consumer_write_address[3*8 +: 8] = 8'h20;
    consumer_write_data[3*8 +: 8]    = 8'h22;
    consumer_write_valid = 4'b1001;
    xact_write(0, 8'h10, 8'h11);
    consumer_write_valid = 4'b1000;
    xact_write(3, 8'h20, 8'h22);
    consumer_write_valid = '0;

    // all four reading continuously
    for (int i = 0; i < 4; i++)
      consumer_read_address[i*8 +: 8] = 8'h40 + 8'(i);
    consumer_read_valid = 4'b1111;
    for (int n = 0; n < 5; n++)
      xact_read(n % 4, 8'h40 + 8'(n % 4), 8'h80 + 8'(n), 0);
    consumer_read_valid = '0;

    // consumer 1 read and write together
    consumer_read_address[1*8 +: 8]  = 8'h55;
    consumer_write_address[1*8 +: 8] = 8'h66;
    consumer_write_data[1*8 +: 8]    = 8'h77;
    consumer_read_valid  = 4'b0010;
    consumer_write_valid = 4'b0010;
    xact_read(1, 8'h55, 8'h99, 0);
    consumer_read_valid = '0;
    xact_write(1, 8'h66, 8'h77);
    consumer_write_valid = '0;

    // reset while in READ_WAIT
    consumer_read_valid = 4'b1000;
    tick;
    chk("ab_valid", mem_read_valid, 1);
    chk("ab_addr", mem_read_address, 8'h43);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("ab_drop", mem_read_valid, 0);
    chk("ab_no_rdy", consumer_read_ready, 0);
    consumer_read_valid = 4'b1001;
    xact_read(0, 8'h40, 8'h31, 0);
    consumer_read_valid = 4'b1000;
    xact_read(3, 8'h43, 8'h32, 0);
    consumer_read_valid = '0;

    // stray memory handshakes
    mem_read_ready = 1'b1;
    tick;
    mem_read_ready = 1'b0;
    chk("sp_idle_rrdy", consumer_read_ready, 0);
    chk("sp_idle_rvld", mem_read_valid, 0);
    mem_write_ready = 1'b1;
    tick;
    mem_write_ready = 1'b0;
    chk("sp_idle_wrdy", consumer_write_ready, 0);
    chk("sp_idle_wvld", mem_write_valid, 0);
    consumer_read_address[2*8 +: 8] = 8'h3C;
    consumer_read_valid = 4'b0100;
    tick;
    chk("sp_rvld", mem_read_valid, 1);
    consumer_read_address[2*8 +: 8] = 8'hEE;
    mem_write_ready = 1'b1;
    tick;
    mem_write_ready = 1'b0;
    chk("sp_still_rvld", mem_read_valid, 1);
    chk("sp_addr_held", mem_read_address, 8'h3C);
    chk("sp_no_wrdy", consumer_write_ready, 0);
    chk("sp_no_rrdy", consumer_read_ready, 0);
    chk("sp_no_wvld", mem_write_valid, 0);
    mem_read_ready = 1'b1;
    mem_read_data  = 8'h5A;
    tick;
    mem_read_ready = 1'b0;
    chk("sp_rrdy", consumer_read_ready, 4'b0100);
    chk("sp_rdata", consumer_read_data[2*8 +: 8], 8'h5A);
    consumer_read_valid = '0;
    tick;
    chk("sp_end", consumer_read_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
